// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC register and next-PC selector with deferred redirects and a timed IF/ID squash.
// Optional macro ALIGN_CHECK_EN vectors misaligned JR targets to EXC_VECTOR and raises AlignErr.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ID_FLUSH   = 1,
  parameter int          EX_FLUSH   = 2,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [27:0] JumpShift,
  input  logic [31:0] JumpPC4,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpReg,
  input  logic [31:0] JumpRegAddr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Flush,
  output logic        Redirect,
  output logic        AlignErr
);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} stateType;

  stateType    state;
  logic [31:0] pc;
  logic [31:0] holdTarget;
  logic        holdEx;
  logic        holdAlign;
  logic [1:0]  flushCnt;
  logic        redirect;
  logic        alignErr;

  logic        reqValid;
  logic        reqEx;
  logic        reqAlign;
  logic [31:0] reqTarget;
  logic        unusedBits;

  // EX-stage requests are older than the ID jump, so they win arbitration.
  always_comb begin
    reqValid  = JumpReg | BranchTaken | Jump;
    reqEx     = JumpReg | BranchTaken;
    reqAlign  = 1'b0;
    reqTarget = {JumpPC4[31:28], JumpShift};
    if (JumpReg) begin
`ifdef ALIGN_CHECK_EN
      if (JumpRegAddr[1:0] != 2'b00) begin
        reqTarget = EXC_VECTOR;
        reqAlign  = 1'b1;
      end else begin
        reqTarget = {JumpRegAddr[31:2], 2'b00};
      end
`else
      reqTarget = {JumpRegAddr[31:2], 2'b00};
`endif
    end else if (BranchTaken) begin
      reqTarget = BranchTarget;
    end
  end

`ifdef ALIGN_CHECK_EN
  assign unusedBits = &{1'b0, JumpPC4[27:0]};
`else
  assign unusedBits = &{1'b0, JumpPC4[27:0], JumpRegAddr[1:0], EXC_VECTOR};
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state      <= RUN;
      pc         <= RESET_PC;
      holdTarget <= '0;
      holdEx     <= 1'b0;
      holdAlign  <= 1'b0;
      flushCnt   <= '0;
      redirect   <= 1'b0;
      alignErr   <= 1'b0;
    end else begin
      redirect <= 1'b0;
      alignErr <= 1'b0;
      case (state)
        RUN: begin
          if (reqValid && Stall) begin
            holdTarget <= reqTarget;
            holdEx     <= reqEx;
            holdAlign  <= reqAlign;
            state      <= HOLD;
          end else if (reqValid) begin
            pc       <= reqTarget;
            redirect <= 1'b1;
            alignErr <= reqAlign;
            flushCnt <= reqEx ? 2'(EX_FLUSH) : 2'(ID_FLUSH);
            state    <= FLUSH;
          end else if (!Stall) begin
            pc <= pc + 32'd4;
          end
        end
        HOLD: begin
          // Only an EX request may displace a held ID jump; the release cycle ignores inputs.
          if (Stall) begin
            if (!holdEx && reqEx) begin
              holdTarget <= reqTarget;
              holdEx     <= 1'b1;
              holdAlign  <= reqAlign;
            end
          end else begin
            pc       <= holdTarget;
            redirect <= 1'b1;
            alignErr <= holdAlign;
            flushCnt <= holdEx ? 2'(EX_FLUSH) : 2'(ID_FLUSH);
            holdEx   <= 1'b0;
            state    <= FLUSH;
          end
        end
        FLUSH: begin
          if (!Stall) begin
            pc       <= pc + 32'd4;
            flushCnt <= flushCnt - 2'd1;
            if (flushCnt == 2'd1) begin
              state <= RUN;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign PC       = pc;
  assign PCPlus4  = pc + 32'd4;
  assign Flush    = (state == FLUSH);
  assign Redirect = redirect;
`ifdef ALIGN_CHECK_EN
  assign AlignErr = alignErr;
`else
  assign AlignErr = 1'b0 & alignErr;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: directed fetch scenarios followed by randomized traffic,
// checked against a pending-redirect/flush-countdown reference model.
module tb_pc_redirect_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          ID_FLUSH   = 1;
  localparam int          EX_FLUSH   = 2;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0180;

  typedef struct {
    bit          rstN;
    bit          stall;
    bit          jump;
    logic [27:0] jumpShift;
    logic [31:0] jumpPc4;
    bit          branch;
    logic [31:0] branchTarget;
    bit          jumpReg;
    logic [31:0] jumpRegAddr;
  } stimT;

  typedef struct {
    logic [31:0] pc;
    bit          flush;
    bit          redirect;
    bit          alignErr;
  } expT;

  logic        Clk = 1'b0;
  logic        Rst_n, Stall, Jump, BranchTaken, JumpReg;
  logic [27:0] JumpShift;
  logic [31:0] JumpPC4, BranchTarget, JumpRegAddr;
  logic [31:0] PC, PCPlus4;
  logic        Flush, Redirect, AlignErr;

  int checks = 0;
  int failures = 0;
  expT expQ[$];

  logic [31:0] mPc;
  int          mFlushLeft;
  bit          mPendValid, mPendEx, mPendAlign, mRedirect, mAlign;
  logic [31:0] mPendTarget;

  pc_redirect_unit #(
    .RESET_PC(RESET_PC), .ID_FLUSH(ID_FLUSH), .EX_FLUSH(EX_FLUSH), .EXC_VECTOR(EXC_VECTOR)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Jump(Jump), .JumpShift(JumpShift),
    .JumpPC4(JumpPC4), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .JumpReg(JumpReg), .JumpRegAddr(JumpRegAddr), .PC(PC), .PCPlus4(PCPlus4),
    .Flush(Flush), .Redirect(Redirect), .AlignErr(AlignErr)
  );

  always #5 Clk = ~Clk;

  // Oldest request wins: register jump, then branch, then the ID jump.
  function automatic void pickRequest(input stimT s, output logic [31:0] tgt, output bit ex,
                                      output bit al);
    al = 1'b0;
    ex = s.jumpReg || s.branch;
    if (s.jumpReg) begin
      tgt = s.jumpRegAddr & 32'hFFFF_FFFC;
`ifdef ALIGN_CHECK_EN
      if (s.jumpRegAddr % 4 != 0) begin
        tgt = EXC_VECTOR;
        al  = 1'b1;
      end
`endif
    end else if (s.branch) begin
      tgt = s.branchTarget;
    end else begin
      tgt = (s.jumpPc4 & 32'hF000_0000) | {4'h0, s.jumpShift};
    end
  endfunction

  function automatic void stepModel(input stimT s);
    logic [31:0] tgt;
    bit ex, al;
    mRedirect = 1'b0;
    mAlign    = 1'b0;
    pickRequest(s, tgt, ex, al);
    if (!s.rstN) begin
      mPc = RESET_PC;
      mFlushLeft = 0;
      mPendValid = 1'b0;
      mPendEx = 1'b0;
      mPendAlign = 1'b0;
    end else if (mFlushLeft > 0) begin
      if (!s.stall) begin
        mPc = mPc + 32'd4;
        mFlushLeft--;
      end
    end else if (mPendValid) begin
      if (s.stall) begin
        if (!mPendEx && ex) begin
          mPendTarget = tgt;
          mPendEx = 1'b1;
          mPendAlign = al;
        end
      end else begin
        mPc = mPendTarget;
        mRedirect = 1'b1;
        mAlign = mPendAlign;
        mFlushLeft = mPendEx ? EX_FLUSH : ID_FLUSH;
        mPendValid = 1'b0;
      end
    end else if (s.jumpReg || s.branch || s.jump) begin
      if (s.stall) begin
        mPendValid = 1'b1;
        mPendTarget = tgt;
        mPendEx = ex;
        mPendAlign = al;
      end else begin
        mPc = tgt;
        mRedirect = 1'b1;
        mAlign = al;
        mFlushLeft = ex ? EX_FLUSH : ID_FLUSH;
      end
    end else if (!s.stall) begin
      mPc = mPc + 32'd4;
    end
  endfunction

  // Drive one cycle of inputs, advance the model, and queue what the DUT should show after the edge.
  task automatic applyStimulus(input stimT s);
    expT e;
    Rst_n = s.rstN;
    Stall = s.stall;
    Jump = s.jump;
    JumpShift = s.jumpShift;
    JumpPC4 = s.jumpPc4;
    BranchTaken = s.branch;
    BranchTarget = s.branchTarget;
    JumpReg = s.jumpReg;
    JumpRegAddr = s.jumpRegAddr;
    stepModel(s);
    @(posedge Clk);
    #1;
    e.pc = mPc;
    e.flush = (mFlushLeft > 0);
    e.redirect = mRedirect;
    e.alignErr = mAlign;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, actual, required);
    end
  endtask

  function automatic stimT idle();
    stimT s;
    s.rstN = 1'b1;
    s.stall = 1'b0;
    s.jump = 1'b0;
    s.jumpShift = '0;
    s.jumpPc4 = '0;
    s.branch = 1'b0;
    s.branchTarget = '0;
    s.jumpReg = 1'b0;
    s.jumpRegAddr = '0;
    return s;
  endfunction

  // Monitor: every cycle the DUT presents a fetch address, compare it with the oldest expectation.
  initial begin
    expT e;
    forever begin
      @(negedge Clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("PC", PC, e.pc);
        checkOutput("PCPlus4", PCPlus4, e.pc + 32'd4);
        checkOutput("Flush", {31'd0, Flush}, {31'd0, e.flush});
        checkOutput("Redirect", {31'd0, Redirect}, {31'd0, e.redirect});
        checkOutput("AlignErr", {31'd0, AlignErr}, {31'd0, e.alignErr});
      end
    end
  end

  initial begin
    stimT s;
    mPc = RESET_PC;
    mFlushLeft = 0;
    mPendValid = 1'b0;
    mPendEx = 1'b0;
    mPendAlign = 1'b0;
    mPendTarget = '0;

    $display("[TB] reset and free-running fetch");
    s = idle(); s.rstN = 1'b0;
    applyStimulus(s);
    applyStimulus(s);
    repeat (3) applyStimulus(idle());

    $display("[TB] ID jump redirect");
    s = idle(); s.jump = 1'b1; s.jumpShift = 28'h040_000C;
    applyStimulus(s);
    applyStimulus(idle());
    s = idle(); s.jump = 1'b1; s.jumpPc4 = 32'h0040_0014; s.jumpShift = 28'h100_0020;
    applyStimulus(s);
    repeat (3) applyStimulus(idle());

    $display("[TB] branch deferred through stall");
    s = idle(); s.stall = 1'b1; s.branch = 1'b1; s.branchTarget = 32'h0000_2000;
    applyStimulus(s);
    s.branch = 1'b0; s.jump = 1'b1; s.jumpShift = 28'h000_5000;
    applyStimulus(s);
    s.jump = 1'b0;
    applyStimulus(s);
    repeat (4) applyStimulus(idle());

    $display("[TB] simultaneous requests and ignored jump during flush");
    s = idle(); s.jumpReg = 1'b1; s.jumpRegAddr = 32'h0000_3000;
    s.branch = 1'b1; s.branchTarget = 32'h0000_4000; s.jump = 1'b1; s.jumpShift = 28'h000_6000;
    applyStimulus(s);
    s = idle(); s.jump = 1'b1; s.jumpShift = 28'h000_7000;
    applyStimulus(s);
    repeat (3) applyStimulus(idle());

    $display("[TB] reset mid-flush");
    s = idle(); s.branch = 1'b1; s.branchTarget = 32'h0000_8000;
    applyStimulus(s);
    applyStimulus(idle());
    s = idle(); s.rstN = 1'b0;
    applyStimulus(s);
    repeat (3) applyStimulus(idle());

    $display("[TB] misaligned register jump");
    s = idle(); s.jumpReg = 1'b1; s.jumpRegAddr = 32'h0000_1002;
    applyStimulus(s);
    repeat (3) applyStimulus(idle());
    s = idle(); s.stall = 1'b1; s.jump = 1'b1; s.jumpShift = 28'h000_9000;
    applyStimulus(s);
    s.jump = 1'b0; s.jumpReg = 1'b1; s.jumpRegAddr = 32'h0000_2003;
    applyStimulus(s);
    repeat (4) applyStimulus(idle());

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      s.rstN = ($urandom_range(63) != 0);
      s.stall = ($urandom_range(3) == 0);
      s.jump = ($urandom_range(4) == 0);
      s.jumpShift = 28'($urandom);
      s.jumpPc4 = $urandom;
      s.branch = ($urandom_range(5) == 0);
      s.branchTarget = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : $urandom;
      s.jumpReg = ($urandom_range(6) == 0);
      s.jumpRegAddr = $urandom;
      applyStimulus(s);
    end
    applyStimulus(idle());

    repeat (2) @(negedge Clk);
    #1;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
